// File: rtl/sysarr_mac_sequencer.sv
// Initiator for one systolic-array MAC cell: streams (x, w) pairs through the cell,
// feeds the running sum back and returns the dot product. Define SYSARR_SEQ_WATCHDOG_EN to add the WAIT watchdog.
module sysarr_mac_sequencer #(
  parameter int DW      = 16,
  parameter int ACC_W   = 32,
  parameter int TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [DW-1:0]    op_x,
  input  logic [DW-1:0]    op_w,
  input  logic             op_last,
  output logic             mac_shift,
  output logic [DW-1:0]    mac_in_value,
  output logic [DW-1:0]    mac_weight,
  output logic             mac_start,
  output logic [ACC_W-1:0] mac_in_accumulate,
  input  logic             mac_value_ready,
  input  logic [ACC_W-1:0] mac_out_accumulate,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_data,
  output logic             busy,
  output logic             err_timeout
);

  typedef enum logic [2:0] {IDLE, LOAD, FIRE, WAIT, DONE} state_t;

  state_t           state;
  logic [DW-1:0]    x_q;
  logic [DW-1:0]    w_q;
  logic             last_q;
  logic [ACC_W-1:0] acc_q;

`ifdef SYSARR_SEQ_WATCHDOG_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0] timer;
`else
  // Constant 0; keeps TIMEOUT referenced when the watchdog is compiled out.
  assign err_timeout = (TIMEOUT < 0);
`endif

  assign mac_in_value      = x_q;
  assign mac_weight        = w_q;
  assign mac_in_accumulate = acc_q;
  assign res_data          = acc_q;

  // Control outputs are registered alongside the state they belong to.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      x_q       <= '0;
      w_q       <= '0;
      last_q    <= 1'b0;
      acc_q     <= '0;
      op_ready  <= 1'b1;
      mac_shift <= 1'b0;
      mac_start <= 1'b0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef SYSARR_SEQ_WATCHDOG_EN
      timer       <= '0;
      err_timeout <= 1'b0;
`endif
    end else begin
      mac_shift <= 1'b0;
      mac_start <= 1'b0;
      case (state)
        IDLE: begin
          if (op_valid) begin
            x_q       <= op_x;
            w_q       <= op_w;
            last_q    <= op_last;
            state     <= LOAD;
            op_ready  <= 1'b0;
            busy      <= 1'b1;
            mac_shift <= 1'b1;
          end
        end
        LOAD: begin
          state     <= FIRE;
          mac_start <= 1'b1;
        end
        FIRE: begin
          state <= WAIT;
`ifdef SYSARR_SEQ_WATCHDOG_EN
          timer <= '0;
`endif
        end
        WAIT: begin
          if (mac_value_ready) begin
            acc_q <= mac_out_accumulate;
            if (last_q) begin
              state     <= DONE;
              res_valid <= 1'b1;
            end else begin
              state    <= IDLE;
              op_ready <= 1'b1;
              busy     <= 1'b0;
            end
          end
`ifdef SYSARR_SEQ_WATCHDOG_EN
          else if (timer == TW'(TIMEOUT - 1)) begin
            err_timeout <= 1'b1;
            acc_q       <= '0;
            state       <= IDLE;
            op_ready    <= 1'b1;
            busy        <= 1'b0;
          end else begin
            timer <= timer + 1'b1;
          end
`endif
        end
        DONE: begin
          if (res_ready) begin
            acc_q     <= '0;
            res_valid <= 1'b0;
            state     <= IDLE;
            op_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          op_ready  <= 1'b1;
          res_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sysarr_mac_sequencer.sv
// Bench for sysarr_mac_sequencer: behavioural MAC cell plus a dot-product reference
// computed from the operand pairs sent. Watchdog checks follow SYSARR_SEQ_WATCHDOG_EN.
module tb_sysarr_mac_sequencer;

  localparam int DW      = 16;
  localparam int ACC_W   = 32;
  localparam int TIMEOUT = 8;

  logic             clk = 1'b0;
  logic             RST;
  logic             op_valid;
  logic             op_ready;
  logic [DW-1:0]    op_x;
  logic [DW-1:0]    op_w;
  logic             op_last;
  logic             mac_shift;
  logic [DW-1:0]    mac_in_value;
  logic [DW-1:0]    mac_weight;
  logic             mac_start;
  logic [ACC_W-1:0] mac_in_accumulate;
  logic             mac_value_ready;
  logic [ACC_W-1:0] mac_out_accumulate;
  logic             res_valid;
  logic             res_ready;
  logic [ACC_W-1:0] res_data;
  logic             busy;
  logic             err_timeout;

  sysarr_mac_sequencer #(.DW(DW), .ACC_W(ACC_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .RST(RST),
    .op_valid(op_valid), .op_ready(op_ready), .op_x(op_x), .op_w(op_w), .op_last(op_last),
    .mac_shift(mac_shift), .mac_in_value(mac_in_value), .mac_weight(mac_weight),
    .mac_start(mac_start), .mac_in_accumulate(mac_in_accumulate),
    .mac_value_ready(mac_value_ready), .mac_out_accumulate(mac_out_accumulate),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0]    x;
    logic [DW-1:0]    w;
    logic [ACC_W-1:0] acc;
  } op_t;

  op_t              exp_q[$];
  op_t              mon_e;
  int               checks = 0;
  int               errors = 0;
  int               n_sent = 0;
  int               n_start = 0;
  int               cnt = 0;
  int               lat = 3;
  logic             mute;
  logic             spur_req;
  logic [DW-1:0]    mv;
  logic [DW-1:0]    wv;
  logic [ACC_W-1:0] acc_at_start;
  logic [ACC_W-1:0] prod;
  logic [ACC_W-1:0] run;
  int unsigned      shift_cyc;
  int unsigned      acc_cyc;
  int unsigned      a;
  int unsigned      s;
  int unsigned      e_cyc;
  logic             rv_seen;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_op_ready"}, 32'(op_ready), 1);
    check_eq({tag, "_busy"}, 32'(busy), 0);
    check_eq({tag, "_shift"}, 32'(mac_shift), 0);
    check_eq({tag, "_start"}, 32'(mac_start), 0);
    check_eq({tag, "_res_valid"}, 32'(res_valid), 0);
    check_eq({tag, "_res_data"}, res_data, 0);
    check_eq({tag, "_in_value"}, 32'(mac_in_value), 0);
    check_eq({tag, "_weight"}, 32'(mac_weight), 0);
    check_eq({tag, "_in_acc"}, mac_in_accumulate, 0);
    check_eq({tag, "_err"}, 32'(err_timeout), 0);
  endtask

  // Behavioural MAC cell: answers lat cycles after the start pulse with x*w + in_accumulate.
  initial forever begin
    @(negedge clk);
    if (RST) begin
      mac_value_ready = 1'b0;
      cnt = 0;
    end else begin
      mac_value_ready = 1'b0;
      if (spur_req) begin
        mac_value_ready = 1'b1;
        mac_out_accumulate = $urandom;
        spur_req = 1'b0;
      end
      if (mac_shift) begin
        shift_cyc = cyc;
        mv = mac_in_value;
        wv = mac_weight;
      end
      if (mac_start) begin
        n_start++;
        check_eq("shift_to_start", cyc - shift_cyc, 1);
        if (exp_q.size() == 0) begin
          check_eq("start_without_op", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check_eq("mac_in_value", 32'(mv), 32'(mon_e.x));
          check_eq("mac_weight", 32'(mac_weight), 32'(mon_e.w));
          check_eq("mac_in_accumulate", mac_in_accumulate, mon_e.acc);
        end
        acc_at_start = mac_in_accumulate;
        prod = 32'(mv) * 32'(mac_weight) + mac_in_accumulate;
        cnt = lat;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0 && !mute) begin
          check_eq("weight_stable", 32'(mac_weight), 32'(wv));
          check_eq("in_acc_stable", mac_in_accumulate, acc_at_start);
          mac_value_ready = 1'b1;
          mac_out_accumulate = prod;
        end
      end
    end
  end

  task automatic send_op(input logic [DW-1:0] x, input logic [DW-1:0] w, input logic last);
    int t = 0;
    op_t e;
    @(negedge clk);
    while (!op_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!op_ready) begin
      check_eq("op_ready_timeout", 32'(op_ready), 1);
      return;
    end
    e.x = x;
    e.w = w;
    e.acc = run;
    exp_q.push_back(e);
    n_sent++;
    run = last ? 32'd0 : run + 32'(x) * 32'(w);
    op_valid = 1'b1;
    op_x = x;
    op_w = w;
    op_last = last;
    @(posedge clk);
    #1 op_valid = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic get_result(input logic [31:0] exp, input int hold, input string tag,
                            output int unsigned seen_cyc);
    int t = 0;
    @(negedge clk);
    while (!res_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    seen_cyc = cyc;
    check_eq({tag, "_valid"}, 32'(res_valid), 1);
    check_eq({tag, "_data"}, res_data, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq({tag, "_hold_valid"}, 32'(res_valid), 1);
      check_eq({tag, "_hold_data"}, res_data, exp);
      check_eq({tag, "_hold_op_ready"}, 32'(op_ready), 0);
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    check_eq({tag, "_drop"}, 32'(res_valid), 0);
    check_eq({tag, "_idle"}, 32'(op_ready), 1);
  endtask

  task automatic run_burst(input int n, input int hold, input string tag);
    logic [31:0]   sum = 0;
    logic [DW-1:0] x;
    logic [DW-1:0] w;
    int unsigned   sc;
    for (int i = 0; i < n; i++) begin
      x = DW'($urandom);
      w = DW'($urandom);
      sum = sum + 32'(x) * 32'(w);
      send_op(x, w, i == n - 1);
    end
    get_result(sum, hold, tag, sc);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    RST = 1'b1;
    op_valid = 1'b0;
    op_x = '0;
    op_w = '0;
    op_last = 1'b0;
    res_ready = 1'b0;
    mac_value_ready = 1'b0;
    mac_out_accumulate = '0;
    mute = 1'b0;
    spur_req = 1'b0;
    run = '0;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk) RST = 1'b0;

    send_op(3, 4, 1'b1);
    a = acc_cyc;
    get_result(12, 0, "single", s);
    check_eq("single_latency", s - a, 5);

    send_op(1, 2, 1'b0);
    a = acc_cyc;
    send_op(3, 4, 1'b0);
    check_eq("b2b_gap", acc_cyc - a, 6);
    send_op(5, 6, 1'b1);
    get_result(44, 0, "dot3", s);

    send_op(1, 2, 1'b0);
    send_op(3, 4, 1'b0);
    send_op(5, 6, 1'b1);
    get_result(44, 5, "bp", s);

    spur_req = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("spur_busy", 32'(busy), 0);
    check_eq("spur_op_ready", 32'(op_ready), 1);
    check_eq("spur_res_valid", 32'(res_valid), 0);
    send_op(7, 8, 1'b1);
    get_result(56, 0, "after_spur", s);

    send_op(5, 7, 1'b0);
    send_op(9, 3, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 check_eq("pre_reset_busy", 32'(busy), 1);
    RST = 1'b1;
    #1 check_reset_outputs("mid_reset");
    exp_q.delete();
    run = '0;
    @(negedge clk);
    @(negedge clk) RST = 1'b0;
    send_op(2, 2, 1'b1);
    get_result(4, 0, "post_reset", s);

    for (int b = 0; b < 30; b++) begin
      lat = $urandom_range(1, 5);
      run_burst($urandom_range(1, 4), $urandom_range(0, 3), "rand");
    end
    lat = 3;

    mute = 1'b1;
    rv_seen = 1'b0;
    e_cyc = 0;
    send_op(9, 9, 1'b1);
    a = acc_cyc;
`ifdef SYSARR_SEQ_WATCHDOG_EN
    repeat (14) begin
      @(negedge clk);
      if (res_valid) rv_seen = 1'b1;
      if (err_timeout && e_cyc == 0) e_cyc = cyc;
    end
    check_eq("wd_err_cycle", e_cyc - a, 10);
    check_eq("wd_err", 32'(err_timeout), 1);
    check_eq("wd_busy", 32'(busy), 0);
    check_eq("wd_op_ready", 32'(op_ready), 1);
    check_eq("wd_no_result", 32'(rv_seen), 0);
    mute = 1'b0;
    run_burst(2, 0, "post_wd");
`else
    repeat (20) begin
      @(negedge clk);
      if (res_valid) rv_seen = 1'b1;
    end
    check_eq("hang_busy", 32'(busy), 1);
    check_eq("hang_err", 32'(err_timeout), 0);
    check_eq("hang_no_result", 32'(rv_seen), 0);
    RST = 1'b1;
    exp_q.delete();
    run = '0;
    mute = 1'b0;
    @(negedge clk);
    @(negedge clk) RST = 1'b0;
    run_burst(2, 0, "post_hang");
`endif

    check_eq("start_count", 32'(n_start), 32'(n_sent));
    check_eq("queue_drained", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
